// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the digit-serial adder/subtractor.
//   state_t  : controller states (IDLE, RUN, DONE)
//   MODE_ADD : M value that selects A + B
//   MODE_SUB : M value that selects A - B
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result handshake bundle for addsub_serial.
//   in_valid/in_ready   : operand handshake (A, B, M)
//   out_valid/out_ready : result handshake (Sum, C_out, ov)
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1; the producer holds its payload
// while valid is 1, and ready may depend on state only.
//   master : the side that issues operands and consumes results
//   slave  : the arithmetic unit
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             M;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             C_out;
    logic             ov;

    modport master (
        output in_valid, A, B, M, out_ready,
        input  in_ready, out_valid, Sum, C_out, ov
    );

    modport slave (
        input  in_valid, A, B, M, out_ready,
        output in_ready, out_valid, Sum, C_out, ov
    );
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple-carry slice.
//   a, b     : DIGIT-bit operand digits (b already conditioned for subtract)
//   cin      : carry into bit 0 of the slice
//   s        : DIGIT-bit sum digit
//   cout     : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (used for signed overflow)
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic carry;

    always_comb begin
        carry    = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// Processes a WIDTH-bit operation DIGIT bits per cycle, LSB digit first,
// taking WIDTH/DIGIT cycles from acceptance to result.
// WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : addsub_serial_if slave (operands in, result out)
//   dbg_state_o : current controller state
// Optional feature macro ADDSUB_SAT_EN: clamp Sum to the signed limit on
// overflow (C_out and ov still describe the raw result).
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addsub_serial_if.slave        bus,
    output state_t                dbg_state_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ov_q, ov_d;

    logic [DIGIT-1:0]   dig_s;
    logic               dig_cout;
    logic               dig_cmsb;
    logic               last_digit;

    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // Operands are shifted right each RUN cycle, so the active digit is
    // always the low DIGIT bits.
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_digit)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.Sum       = sum_q;
        bus.C_out     = cout_q;
        bus.ov        = ov_q;
        dbg_state_o   = state_q;
    end

    // Datapath next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is A + ~B + 1: M is fully absorbed into the
                    // inverted B and the initial carry, so it is not kept.
                    a_d     = bus.A;
                    b_d     = bus.B ^ {WIDTH{bus.M}};
                    carry_d = bus.M;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                // New digit enters at the top; after N cycles digit 0 has
                // reached the bottom of the result register.
                sum_d   = WIDTH'({dig_s, sum_q} >> DIGIT);
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    cnt_d  = '0;
                    cout_d = dig_cout;
                    ov_d   = dig_cout ^ dig_cmsb;
`ifdef ADDSUB_SAT_EN
                    // On overflow the raw sign is the inverse of A's sign,
                    // so the clamp direction follows from the raw MSB.
                    if (dig_cout ^ dig_cmsb) begin
                        sum_d = {~sum_d[WIDTH-1], {(WIDTH-1){sum_d[WIDTH-1]}}};
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: self-checking bench for addsub_serial.
// Four instances cover WIDTH=4 with DIGIT=1,2,4 and WIDTH=16 with DIGIT=4.
// Expected results come from signed/unsigned integer arithmetic.
module tb_addsub_serial;
    import addsub_pkg::*;

    localparam int NDUT = 4;
    localparam int EW   = 18;  // {ov, C_out, Sum[15:0]}

    int wid [NDUT] = '{4, 4, 4, 16};
    int dig [NDUT] = '{1, 2, 4, 4};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        vld_d  [NDUT];
    logic        m_d    [NDUT];
    logic        ordy_d [NDUT];
    logic [15:0] a_d    [NDUT];
    logic [15:0] b_d    [NDUT];

    logic        irdy_o [NDUT];
    logic        oval_o [NDUT];
    logic        cout_o [NDUT];
    logic        ov_o   [NDUT];
    logic [15:0] sum_o  [NDUT];
    state_t      st_o   [NDUT];

    logic [EW-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    addsub_serial_if #(.WIDTH(4))  if0 ();
    addsub_serial_if #(.WIDTH(4))  if1 ();
    addsub_serial_if #(.WIDTH(4))  if2 ();
    addsub_serial_if #(.WIDTH(16)) if3 ();

    addsub_serial #(.WIDTH(4), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state_o(st_o[0]));
    addsub_serial #(.WIDTH(4), .DIGIT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state_o(st_o[1]));
    addsub_serial #(.WIDTH(4), .DIGIT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .dbg_state_o(st_o[2]));
    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_state_o(st_o[3]));

    assign if0.in_valid = vld_d[0];
    assign if0.A        = a_d[0][3:0];
    assign if0.B        = b_d[0][3:0];
    assign if0.M        = m_d[0];
    assign if0.out_ready = ordy_d[0];
    assign irdy_o[0]    = if0.in_ready;
    assign oval_o[0]    = if0.out_valid;
    assign cout_o[0]    = if0.C_out;
    assign ov_o[0]      = if0.ov;
    assign sum_o[0]     = 16'(if0.Sum);

    assign if1.in_valid = vld_d[1];
    assign if1.A        = a_d[1][3:0];
    assign if1.B        = b_d[1][3:0];
    assign if1.M        = m_d[1];
    assign if1.out_ready = ordy_d[1];
    assign irdy_o[1]    = if1.in_ready;
    assign oval_o[1]    = if1.out_valid;
    assign cout_o[1]    = if1.C_out;
    assign ov_o[1]      = if1.ov;
    assign sum_o[1]     = 16'(if1.Sum);

    assign if2.in_valid = vld_d[2];
    assign if2.A        = a_d[2][3:0];
    assign if2.B        = b_d[2][3:0];
    assign if2.M        = m_d[2];
    assign if2.out_ready = ordy_d[2];
    assign irdy_o[2]    = if2.in_ready;
    assign oval_o[2]    = if2.out_valid;
    assign cout_o[2]    = if2.C_out;
    assign ov_o[2]      = if2.ov;
    assign sum_o[2]     = 16'(if2.Sum);

    assign if3.in_valid = vld_d[3];
    assign if3.A        = a_d[3];
    assign if3.B        = b_d[3];
    assign if3.M        = m_d[3];
    assign if3.out_ready = ordy_d[3];
    assign irdy_o[3]    = if3.in_ready;
    assign oval_o[3]    = if3.out_valid;
    assign cout_o[3]    = if3.C_out;
    assign ov_o[3]      = if3.ov;
    assign sum_o[3]     = if3.Sum;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Integer arithmetic on the operands' signed and unsigned values.
    function automatic logic [EW-1:0] model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic m);
        longint modv, half, ua, ub, sa, sb, ures, sres, smax, smin;
        logic   cout, ovf;
        logic [15:0] sum;
        modv = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) % modv;
        ub   = longint'(b) % modv;
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        smax = half - 1;
        smin = -half;
        if (m == MODE_SUB) begin
            ures = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);        // 1 means no borrow
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            cout = (ures >= modv);
        end
        ovf = (sres > smax) || (sres < smin);
        sum = 16'((ures + modv) % modv);
`ifdef ADDSUB_SAT_EN
        if (ovf) sum = (sres > smax) ? 16'(smax) : 16'(half);
`endif
        return {ovf, cout, sum};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic scramble(input int k);
        a_d[k]   = 16'($urandom);
        b_d[k]   = 16'($urandom);
        m_d[k]   = 1'($urandom_range(0, 1));
        vld_d[k] = 1'($urandom_range(0, 1));
    endtask

    // Issue one operation on instance k, hold out_ready low for `hold`
    // cycles after out_valid, then take the result.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input int hold);
        int            cyc;
        logic [15:0]   mask;
        logic [EW-1:0] exp;
        mask = 16'((32'd1 << wid[k]) - 1);

        cyc = 0;
        while (!irdy_o[k] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("in_ready_wait[%0d]", k), 32'(irdy_o[k]), 32'd1);

        a_d[k]   = a & mask;
        b_d[k]   = b & mask;
        m_d[k]   = m;
        vld_d[k] = 1'b1;
        exp_q.push_back(model(wid[k], a & mask, b & mask, m));
        @(posedge clk);                    // acceptance edge
        #1;
        vld_d[k] = 1'b0;

        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!oval_o[k]) check($sformatf("run_in_ready[%0d]", k), 32'(irdy_o[k]), 32'd0);
            scramble(k);
        end while (!oval_o[k] && cyc < 100);
        check($sformatf("latency[%0d]", k), 32'(cyc), 32'(wid[k] / dig[k]));

        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end

        for (int i = 0; i < hold; i++) begin
            check($sformatf("hold_sum[%0d]", k), 32'(sum_o[k]), 32'(exp[15:0]));
            check($sformatf("hold_valid[%0d]", k), 32'(oval_o[k]), 32'd1);
            check($sformatf("hold_in_ready[%0d]", k), 32'(irdy_o[k]), 32'd0);
            scramble(k);
            @(negedge clk);
        end

        vld_d[k]  = 1'b0;
        ordy_d[k] = 1'b1;
        check($sformatf("out_valid[%0d]", k), 32'(oval_o[k]), 32'd1);
        check($sformatf("sum[%0d] a=%0h b=%0h m=%0b", k, a & mask, b & mask, m),
              32'(sum_o[k]), 32'(exp[15:0]));
        check($sformatf("c_out[%0d]", k), 32'(cout_o[k]), 32'(exp[16]));
        check($sformatf("ov[%0d]", k), 32'(ov_o[k]), 32'(exp[17]));
        @(negedge clk);                    // handshake edge has passed
        ordy_d[k] = 1'b0;
        check($sformatf("released_valid[%0d]", k), 32'(oval_o[k]), 32'd0);
        check($sformatf("released_in_ready[%0d]", k), 32'(irdy_o[k]), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            vld_d[k] = 1'b0; m_d[k] = 1'b0; ordy_d[k] = 1'b0;
            a_d[k] = '0; b_d[k] = '0;
        end

        // Reset state, observed while rst_n is still low
        #12;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_in_ready[%0d]", k), 32'(irdy_o[k]), 32'd1);
            check($sformatf("rst_out_valid[%0d]", k), 32'(oval_o[k]), 32'd0);
            check($sformatf("rst_sum[%0d]", k), 32'(sum_o[k]), 32'd0);
            check($sformatf("rst_c_out[%0d]", k), 32'(cout_o[k]), 32'd0);
            check($sformatf("rst_ov[%0d]", k), 32'(ov_o[k]), 32'd0);
            check($sformatf("rst_state[%0d]", k), 32'(st_o[k]), 32'(IDLE));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(0, 16'h5, 16'hA, MODE_ADD, 0);
        run_op(1, 16'h9, 16'h5, MODE_SUB, 1);
        run_op(1, 16'hA, 16'hA, MODE_SUB, 0);
        run_op(2, 16'hF, 16'hF, MODE_ADD, 2);
        for (int k = 0; k < NDUT; k++) run_op(k, 16'h7, 16'h1, MODE_ADD, 0);
        run_op(3, 16'h7FFF, 16'h0001, MODE_ADD, 0);
        run_op(3, 16'h8000, 16'h0001, MODE_SUB, 1);
        run_op(3, 16'h0000, 16'h0000, MODE_SUB, 0);
        run_op(3, 16'h1234, 16'hABCD, MODE_ADD, 10);   // long back-pressure

        // Random operations on every instance
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 20; i++) begin
                run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3));
            end
        end

        // Reset during the second RUN cycle of the 16-bit instance
        run_op(3, 16'hFFFF, 16'h7FFF, MODE_ADD, 0);    // leaves nonzero outputs
        a_d[3] = 16'h1111; b_d[3] = 16'h2222; m_d[3] = MODE_ADD; vld_d[3] = 1'b1;
        @(posedge clk);                                // acceptance edge
        #1;
        vld_d[3] = 1'b0;
        @(posedge clk);                                // first RUN edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_sum", 32'(sum_o[3]), 32'd0);
        check("midrun_rst_c_out", 32'(cout_o[3]), 32'd0);
        check("midrun_rst_ov", 32'(ov_o[3]), 32'd0);
        check("midrun_rst_out_valid", 32'(oval_o[3]), 32'd0);
        check("midrun_rst_in_ready", 32'(irdy_o[3]), 32'd1);
        check("midrun_rst_state", 32'(st_o[3]), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3, 16'h4321, 16'h1234, MODE_SUB, 2);
        run_op(3, 16'h8000, 16'h8000, MODE_ADD, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
